// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants, stall-vector indices and the per-edge action decode for the EX/MEM register.
package ex_mem_pipe_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 2;
  localparam int DEF_STALL_W    = 6;
  localparam int BUBBLE_CNT_W   = 16;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [DEF_REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [DEF_DATA_W-1:0]     ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } pipe_act_e;

  function automatic pipe_act_e decode_act(input logic flush, input logic stall_ex,
                                           input logic stall_mem);
    if (flush) return ACT_FLUSH;
    // MEM stalled freezes the register whether or not EX is stalled (MEM-only is illegal, held)
    if (stall_mem) return ACT_HOLD;
    if (stall_ex) return ACT_BUBBLE;
    return ACT_NORMAL;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register, including the MADD/MSUB feedback.
interface ex_mem_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2
);

  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_wdata;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic                  ex_whilo;
  logic [2*DATA_W-1:0]   hilo_temp_i;
  logic [CNT_W-1:0]      cnt_i;

  logic [REG_ADDR_W-1:0] mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic                  mem_whilo;
  logic                  mem_valid;
  logic [2*DATA_W-1:0]   hilo_temp_o;
  logic [CNT_W-1:0]      cnt_o;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_valid,
           hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_valid,
           hilo_temp_o, cnt_o
  );

endinterface

// File: rtl/ex_mem_pipe_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush/bubble handling and MADD/MSUB state feedback.
// Build option: define EX_MEM_BUBBLE_CNT_EN to add the saturating EX-stall bubble counter output.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STALL_W    = DEF_STALL_W,
  parameter int EX_IDX     = STALL_EX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
`ifdef EX_MEM_BUBBLE_CNT_EN
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt,
`endif
  ex_mem_pipe_if.slave       bus
);

  pipe_act_e act;

  logic [REG_ADDR_W-1:0] mem_wd_q, mem_wd_d;
  logic                  mem_wreg_q, mem_wreg_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     mem_hi_q, mem_hi_d;
  logic [DATA_W-1:0]     mem_lo_q, mem_lo_d;
  logic                  mem_whilo_q, mem_whilo_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [2*DATA_W-1:0]   hilo_temp_q, hilo_temp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Only the EX and MEM bits steer this register; the rest are deliberately ignored.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  assign act = decode_act(flush, stall[EX_IDX], stall[EX_IDX+1]);

  always_comb begin
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_whilo_d = mem_whilo_q;
    mem_valid_d = mem_valid_q;
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;

    if (act == ACT_FLUSH || act == ACT_BUBBLE) begin
      mem_wd_d    = REG_ADDR_W'(NOP_REG_ADDR);
      mem_wreg_d  = WRITE_DISABLE;
      mem_wdata_d = DATA_W'(ZERO_WORD);
      mem_hi_d    = DATA_W'(ZERO_WORD);
      mem_lo_d    = DATA_W'(ZERO_WORD);
      mem_whilo_d = WRITE_DISABLE;
      mem_valid_d = 1'b0;
    end

    case (act)
      ACT_NORMAL: begin
        mem_wd_d    = bus.ex_wd;
        mem_wreg_d  = bus.ex_wreg;
        mem_wdata_d = bus.ex_wdata;
        mem_hi_d    = bus.ex_hi;
        mem_lo_d    = bus.ex_lo;
        mem_whilo_d = bus.ex_whilo;
        mem_valid_d = 1'b1;
        hilo_temp_d = '0;
        cnt_d       = '0;
      end
      ACT_BUBBLE: begin
        // EX is re-executing the same multi-cycle op next cycle; hand its partial state back.
        hilo_temp_d = bus.hilo_temp_i;
        cnt_d       = bus.cnt_i;
      end
      ACT_FLUSH: begin
        hilo_temp_d = '0;
        cnt_d       = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_wd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_whilo_q <= 1'b0;
      mem_valid_q <= 1'b0;
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_whilo_q <= mem_whilo_d;
      mem_valid_q <= mem_valid_d;
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_wd      = mem_wd_q;
  assign bus.mem_wreg    = mem_wreg_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_hi      = mem_hi_q;
  assign bus.mem_lo      = mem_lo_q;
  assign bus.mem_whilo   = mem_whilo_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.hilo_temp_o = hilo_temp_q;
  assign bus.cnt_o       = cnt_q;

`ifdef EX_MEM_BUBBLE_CNT_EN
  sat_counter #(.W(BUBBLE_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_BUBBLE),
    .count (bubble_cnt)
  );
`endif

  a_stall_combo : assert property (@(posedge clk) disable iff (rst)
    !(!flush && !stall[EX_IDX] && stall[EX_IDX+1]));

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: driver pushes hand-computed expectations, monitor pops and checks.
module tb_ex_mem_pipe;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        valid;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic [15:0] bub;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  logic [15:0] bub_out;

  int total;
  int bad;
  exp_t exp_q[$];
  logic [15:0] bub_model;

  ex_mem_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) bus ();

`ifdef EX_MEM_BUBBLE_CNT_EN
  ex_mem_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .bubble_cnt (bub_out),
    .bus        (bus)
  );
`else
  assign bub_out = 16'h0;
  ex_mem_pipe dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, act, want);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".wd"},    64'(bus.mem_wd),      64'(e.wd));
    chk({tag, ".wreg"},  64'(bus.mem_wreg),    64'(e.wreg));
    chk({tag, ".wdata"}, 64'(bus.mem_wdata),   64'(e.wdata));
    chk({tag, ".hi"},    64'(bus.mem_hi),      64'(e.hi));
    chk({tag, ".lo"},    64'(bus.mem_lo),      64'(e.lo));
    chk({tag, ".whilo"}, 64'(bus.mem_whilo),   64'(e.whilo));
    chk({tag, ".valid"}, 64'(bus.mem_valid),   64'(e.valid));
    chk({tag, ".temp"},  bus.hilo_temp_o,      e.temp);
    chk({tag, ".cnt"},   64'(bus.cnt_o),       64'(e.cnt));
`ifdef EX_MEM_BUBBLE_CNT_EN
    chk({tag, ".bub"},   64'(bub_out),         64'(e.bub));
`endif
  endtask

  function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                              input logic valid, input logic [63:0] temp, input logic [1:0] cnt);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.hi = hi; e.lo = lo;
    e.whilo = whilo; e.valid = valid; e.temp = temp; e.cnt = cnt; e.bub = 16'h0;
    return e;
  endfunction

  function automatic logic [15:0] bub_next(input logic [15:0] b, input logic [5:0] st,
                                           input logic fl);
    if (!fl && st[3] && !st[4] && b != 16'hFFFF) return b + 16'd1;
    return b;
  endfunction

  task automatic step(input logic [5:0] st, input logic fl, input logic [4:0] wd,
                      input logic wreg, input logic [31:0] wdata, input logic [31:0] hi,
                      input logic [31:0] lo, input logic whilo, input logic [63:0] ti,
                      input logic [1:0] ci, input exp_t e);
    exp_t ee;
    @(negedge clk);
    stall = st; flush = fl;
    bus.ex_wd = wd; bus.ex_wreg = wreg; bus.ex_wdata = wdata;
    bus.ex_hi = hi; bus.ex_lo = lo; bus.ex_whilo = whilo;
    bus.hilo_temp_i = ti; bus.cnt_i = ci;
    bub_model = bub_next(bub_model, st, fl);
    ee = e;
    ee.bub = bub_model;
    exp_q.push_back(ee);
  endtask

  // Monitor: each expectation is for the edge that follows its push.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all("edge", e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "time limit");
  end

  localparam logic [63:0] T12 = 64'h0000_0001_0000_0002;
  localparam logic [63:0] T34 = 64'h0000_0003_0000_0004;
  localparam logic [63:0] TAA = 64'hAAAA_5555_0F0F_F0F0;
  exp_t z;

  initial begin
    total = 0; bad = 0; bub_model = 16'h0;
    z = mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    bus.ex_wd = 5'd0; bus.ex_wreg = 1'b0; bus.ex_wdata = 32'h0; bus.ex_hi = 32'h0;
    bus.ex_lo = 32'h0; bus.ex_whilo = 1'b0; bus.hilo_temp_i = 64'h0; bus.cnt_i = 2'd0;
    #1;
    check_all("reset", z);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;

    // Pass-through, then asynchronous reset between edges.
    step(6'b0, 1'b0, 5'd3, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
         mk(5'd3, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 2'd0));
    @(posedge clk); #3 rst = 1'b1; bub_model = 16'h0;
    #1;
    check_all("rst_async", z);
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;
    step(6'b0, 1'b0, 5'd3, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
         mk(5'd3, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 2'd0));

    // Pass-through clears multi-cycle state even if EX offers some.
    step(6'b0, 1'b0, 5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1, 64'hFFFF_0000_FFFF_0000, 2'd3,
         mk(5'd7, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1, 1'b1, 64'h0, 2'd0));

    // EX stall: bubble out, partial state fed back.
    step(6'b001111, 1'b0, 5'd9, 1'b1, 32'hCAFE, 32'h1, 32'h2, 1'b1, T12, 2'd1,
         mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, T12, 2'd1));
    step(6'b001111, 1'b0, 5'd9, 1'b1, 32'hCAFE, 32'h1, 32'h2, 1'b1, T34, 2'd2,
         mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, T34, 2'd2));

    // Double stall holds the bubble and the fed-back state.
    step(6'b011111, 1'b0, 5'd1, 1'b1, 32'h111, 32'h5, 32'h6, 1'b1, TAA, 2'd3,
         mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, T34, 2'd2));

    // Pass wdata=0x55, then three double-stall cycles with changing EX inputs.
    step(6'b0, 1'b0, 5'd4, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
         mk(5'd4, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      step(6'b011111, 1'b0, 5'(i + 10), 1'b0, 32'h100 + 32'(i), 32'(i), 32'(i), 1'b1, TAA, 2'd1,
           mk(5'd4, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 2'd0));
    end

    // Build up partial state, then flush beats the EX stall and clears it.
    step(6'b001111, 1'b0, 5'd2, 1'b1, 32'h77, 32'h0, 32'h0, 1'b0, TAA, 2'd3,
         mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, TAA, 2'd3));
    step(6'b001111, 1'b1, 5'd2, 1'b1, 32'h77, 32'h8, 32'h9, 1'b1, T12, 2'd2, z);

    // Non-EX/MEM stall bits do not affect pass-through.
    step(6'b100111, 1'b0, 5'd31, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 1'b1, TAA, 2'd1,
         mk(5'd31, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 1'b1, 1'b1, 64'h0, 2'd0));
    // Flush with no stall kills a real instruction.
    step(6'b0, 1'b1, 5'd5, 1'b1, 32'h1234, 32'h1, 32'h1, 1'b1, T12, 2'd1, z);
    step(6'b0, 1'b0, 5'd6, 1'b1, 32'h6666, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
         mk(5'd6, 1'b1, 32'h6666, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 2'd0));

`ifdef EX_MEM_BUBBLE_CNT_EN
    @(negedge clk); rst = 1'b1; bub_model = 16'h0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(6'b001111, 1'b0, 5'd1, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0, T12, 2'd1,
           mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, T12, 2'd1));
    end
    for (int i = 0; i < 2; i++) step(6'b001111, 1'b1, 5'd1, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0,
                                     T12, 2'd1, z);
    @(posedge clk); #1;
    chk("bub_after_flush", 64'(bub_out), 64'd5);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      stall = 6'b001111; flush = 1'b0;
      bub_model = bub_next(bub_model, stall, flush);
    end
    step(6'b001111, 1'b0, 5'd1, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0, T34, 2'd2,
         mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, T34, 2'd2));
    @(posedge clk); #1;
    chk("bub_saturated", 64'(bub_out), 64'hFFFF);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
